// File: rtl/full_adder_checker.sv
// Built-in self-test engine for a one-bit full adder: sweeps all eight
// (A, B, Cin) vectors, samples the adder after SETTLE cycles and records mismatches.
module full_adder_checker #(
  parameter int SETTLE = 1,
  parameter int ERRW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            a_o,
  output logic            b_o,
  output logic            cin_o,
  input  logic            s_i,
  input  logic            cout_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic            fail_valid,
  output logic [2:0]      first_fail
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_vec;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [ERRW-1:0] r_err;
  logic            r_fv;
  logic [2:0]      r_ff;

  logic            w_accept;
  logic            w_expire;
  logic            w_last;
  logic            w_exp_s;
  logic            w_exp_c;
  logic            w_mis;
  logic [ERRW-1:0] w_err_next;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // r_vec is both the vector index and the {cin, b, a} operands.
  assign w_exp_s    = r_vec[0] ^ r_vec[1] ^ r_vec[2];
  assign w_exp_c    = (r_vec[0] & r_vec[1]) | (r_vec[0] & r_vec[2]) | (r_vec[1] & r_vec[2]);
  assign w_mis      = (s_i != w_exp_s) || (cout_i != w_exp_c);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_expire   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_last     = (r_vec == 3'd7);
  assign w_err_next = w_mis ? sat_inc(r_err) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = w_last ? S_IDLE : S_CHECK;
      S_CHECK: w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Sampling happens on the edge the settle count expires; the following
  // CHECK cycle advances to the next vector, giving SETTLE+1 cycles per vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_fv   <= 1'b0;
      r_ff   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_vec  <= '0;
        r_cnt  <= CNT_LOAD;
        r_busy <= 1'b1;
        r_pass <= 1'b0;
        r_err  <= '0;
        r_fv   <= 1'b0;
        r_ff   <= '0;
      end else if (w_expire) begin
        r_err <= w_err_next;
        if (w_mis && !r_fv) begin
          r_fv <= 1'b1;
          r_ff <= r_vec;
        end
        if (w_last) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_vec  <= '0;
          r_pass <= (w_err_next == '0);
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_CHECK) begin
        r_vec <= r_vec + 3'd1;
        r_cnt <= CNT_LOAD;
      end
    end
  end

  assign a_o        = r_vec[0];
  assign b_o        = r_vec[1];
  assign cin_o      = r_vec[2];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_valid = r_fv;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_full_adder_checker.sv
// Scoreboard bench: two checker instances drive modelled adders with selectable
// faults; expected run results are queued at start and checked on done.
module tb_full_adder_checker;

  typedef struct {
    int err;
    int fv;
    int ff;
    int pass;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // u0: SETTLE=1 ERRW=4, u1: SETTLE=2 ERRW=2
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
  logic [1:0] err1;
  logic [2:0] ff1;
  int         mode0 = 0, mode1 = 0;  // 0 good, 1 S stuck 0, 2 Cout inverted, 3 registered
  logic       rs0 = 1'b0, rc0 = 1'b0, rs1 = 1'b0, rc1 = 1'b0;
  exp_t       q0[$];
  exp_t       q1[$];
  int         bcnt0 = 0, bcnt1 = 0;

  always #5 clk = ~clk;

  full_adder_checker #(.SETTLE(1), .ERRW(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0), .cin_o(c0),
    .s_i(s0), .cout_i(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_valid(fv0), .first_fail(ff0));

  full_adder_checker #(.SETTLE(2), .ERRW(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1), .cin_o(c1),
    .s_i(s1), .cout_i(co1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .first_fail(ff1));

  always @(posedge clk) begin
    rs0 <= a0 ^ b0 ^ c0;
    rc0 <= (a0 & b0) | (a0 & c0) | (b0 & c0);
    rs1 <= a1 ^ b1 ^ c1;
    rc1 <= (a1 & b1) | (a1 & c1) | (b1 & c1);
  end

  always_comb begin
    s0  = a0 ^ b0 ^ c0;
    co0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
    case (mode0)
      1: s0 = 1'b0;
      2: co0 = ~((a0 & b0) | (a0 & c0) | (b0 & c0));
      3: begin s0 = rs0; co0 = rc0; end
      default: ;
    endcase
  end

  always_comb begin
    s1  = a1 ^ b1 ^ c1;
    co1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
    case (mode1)
      1: s1 = 1'b0;
      2: co1 = ~((a1 & b1) | (a1 & c1) | (b1 & c1));
      3: begin s1 = rs1; co1 = rc1; end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic cmp_run(input string who, input exp_t e, input int err, input int fv,
                         input int ff, input int pss, input int lat);
    chk({who, "_err_cnt"}, err, e.err);
    chk({who, "_fail_valid"}, fv, e.fv);
    if (e.fv != 0) chk({who, "_first_fail"}, ff, e.ff);
    chk({who, "_pass"}, pss, e.pass);
    chk({who, "_busy_cycles"}, lat, e.lat);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy0) bcnt0++;
    if (done0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        cmp_run("u0", e, int'(err0), int'(fv0), int'(ff0), int'(pass0), bcnt0);
      end
    end
    if (!busy0) bcnt0 = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy1) bcnt1++;
    if (done1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        cmp_run("u1", e, int'(err1), int'(fv1), int'(ff1), int'(pass1), bcnt1);
      end
    end
    if (!busy1) bcnt1 = 0;
  end

  task automatic wait_empty(input int which);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("run_timeout", 1, 0);
  endtask

  task automatic run(input int which, input int e_err, input int e_fv, input int e_ff,
                     input int e_pass);
    exp_t e;
    e.err = e_err; e.fv = e_fv; e.ff = e_ff; e.pass = e_pass;
    e.lat = (which == 0) ? 15 : 23;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    if (which == 0) begin
      chk("u0_start_busy", busy0, 1);
      chk("u0_start_err_clr", err0, 0);
      chk("u0_start_pass_clr", pass0, 0);
      chk("u0_start_fv_clr", fv0, 0);
    end else begin
      chk("u1_start_busy", busy1, 1);
      chk("u1_start_err_clr", err1, 0);
      chk("u1_start_pass_clr", pass1, 0);
    end
    wait_empty(which);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_ops"}, {c0, b0, a0}, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_fv"}, fv0, 0);
    chk({tag, "_ff"}, ff0, 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    repeat (3) @(negedge clk);
    chk_reset0("rst_u0");
    chk("rst_u1_busy", busy1, 0);
    chk("rst_u1_err", err1, 0);
    chk("rst_u1_ops", {c1, b1, a1}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode0 = 0; run(0, 0, 0, 0, 1);
    mode0 = 1; run(0, 4, 1, 1, 0);
    mode0 = 2; run(0, 8, 1, 0, 0);
    mode0 = 3; run(0, 5, 1, 1, 0);
    mode1 = 3; run(1, 0, 0, 0, 1);
    mode1 = 2; run(1, 3, 1, 0, 0);

    // start held high: no restart mid-run, then a back-to-back run from the done cycle
    mode0 = 0;
    e.err = 0; e.fv = 0; e.ff = 0; e.pass = 1; e.lat = 15; q0.push_back(e);
    e.err = 4; e.fv = 1; e.ff = 1; e.pass = 0; e.lat = 15; q0.push_back(e);
    @(negedge clk);
    start0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done0 && n < 100);
    chk("held_first_done", done0, 1);
    chk("held_first_pass", pass0, 1);
    mode0 = 1;
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_busy", busy0, 1);
    chk("b2b_pass_clr", pass0, 0);
    chk("b2b_err_clr", err0, 0);
    wait_empty(0);

    // asynchronous reset while vector 4 is driven
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!(busy0 && {c0, b0, a0} == 3'b100) && n < 50) begin @(negedge clk); n++; end
    chk("abort_reached_vec4", {c0, b0, a0}, 3'b100);
    #1 rst_n = 1'b0;
    #1 chk_reset0("abort");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_idle", busy0, 0);
    run(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
